// File: rtl/registro_pkg.sv
// Shared constants and state encoding for the universal shift register family.
package registro_pkg;

  // Operation select encoding
  localparam logic [2:0] MODO_SHIFT  = 3'b000;
  localparam logic [2:0] MODO_ROT    = 3'b001;
  localparam logic [2:0] MODO_LOAD   = 3'b010;
  localparam logic [2:0] MODO_HOLD   = 3'b011;
  localparam logic [2:0] MODO_ASHIFT = 3'b100;

  // Shift direction
  localparam logic DIR_IZQ = 1'b0;  // towards MSB
  localparam logic DIR_DER = 1'b1;  // towards LSB

  // Burst controller states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } estado_e;

  // True for operations that move bits (and therefore update s_out)
  function automatic logic es_paso(input logic [2:0] op);
    return (op == MODO_SHIFT) || (op == MODO_ROT) || (op == MODO_ASHIFT);
  endfunction

endpackage

// File: rtl/registro_paso.sv
// Combinational single-step next value of the universal shift register.
module registro_paso #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             dir_i,
  input  logic [2:0]       op_i,
  input  logic             s_in_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             bit_out_o
);
  import registro_pkg::*;

  // Next value for one step of the selected operation
  always_comb begin
    q_next_o  = q_i;
    bit_out_o = (dir_i == DIR_DER) ? q_i[0] : q_i[WIDTH-1];
    case (op_i)
      MODO_SHIFT: begin
        if (dir_i == DIR_DER) q_next_o = {s_in_i, q_i[WIDTH-1:1]};
        else                  q_next_o = {q_i[WIDTH-2:0], s_in_i};
      end
      MODO_ROT: begin
        if (dir_i == DIR_DER) q_next_o = {q_i[0], q_i[WIDTH-1:1]};
        else                  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      end
      MODO_LOAD: q_next_o = d_i;
      MODO_ASHIFT: begin
        // Left arithmetic shift fills with zero; s_in is not used
        if (dir_i == DIR_DER) q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        else                  q_next_o = {q_i[WIDTH-2:0], 1'b0};
      end
      default: q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/registro_universal.sv
// WIDTH-bit universal shift register with free-run mode and counted bursts.
module registro_universal #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [2:0]       modo,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);
  import registro_pkg::*;

  estado_e          estado_q, estado_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;
  logic [2:0]       op_q, op_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    resto_q, resto_d;  // steps still to perform in the burst

  logic [2:0]       op_sel;
  logic             dir_sel;
  logic [WIDTH-1:0] q_paso;
  logic             bit_paso;

  // During a burst the step unit follows the latched command, otherwise live inputs
  always_comb begin
    op_sel  = (estado_q == StRun) ? op_q  : modo;
    dir_sel = (estado_q == StRun) ? dir_q : dir;
  end

  registro_paso #(
    .WIDTH (WIDTH)
  ) u_paso (
    .q_i       (q_q),
    .dir_i     (dir_sel),
    .op_i      (op_sel),
    .s_in_i    (s_in),
    .d_i       (d),
    .q_next_o  (q_paso),
    .bit_out_o (bit_paso)
  );

  // Next-state logic: free-run in idle, counted steps in run, one-cycle completion
  always_comb begin
    estado_d = estado_q;
    q_d      = q_q;
    s_out_d  = s_out_q;
    op_d     = op_q;
    dir_d    = dir_q;
    resto_d  = resto_q;
    if (enb) begin
      case (estado_q)
        StIdle: begin
          if (start) begin
            op_d    = modo;
            dir_d   = dir;
            resto_d = cnt;
            if (es_paso(modo) && (cnt != '0)) estado_d = StRun;
            else                               estado_d = StFin;
          end else begin
            q_d = q_paso;
            if (es_paso(modo)) s_out_d = bit_paso;
          end
        end
        StRun: begin
          q_d     = q_paso;
          s_out_d = bit_paso;
          resto_d = resto_q - CW'(1);
          if (resto_q == CW'(1)) estado_d = StFin;
        end
        StFin: begin
          estado_d = StIdle;
        end
        default: estado_d = StIdle;
      endcase
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= StIdle;
      q_q      <= '0;
      s_out_q  <= 1'b0;
      op_q     <= MODO_HOLD;
      dir_q    <= DIR_IZQ;
      resto_q  <= '0;
    end else begin
      estado_q <= estado_d;
      q_q      <= q_d;
      s_out_q  <= s_out_d;
      op_q     <= op_d;
      dir_q    <= dir_d;
      resto_q  <= resto_d;
    end
  end

  // Outputs decoded straight from registered state
  always_comb begin
    q     = q_q;
    s_out = s_out_q;
    busy  = (estado_q == StRun);
    done  = (estado_q == StFin);
  end

endmodule

// File: tb/tb_registro_universal.sv
// Directed self-checking bench for registro_universal (WIDTH=4 and WIDTH=8).
module tb_registro_universal;

  logic       clk;
  logic       rst_n;

  logic       enb, dir, s_in, start;
  logic [2:0] modo;
  logic [3:0] d;
  logic [2:0] cnt;
  logic [3:0] q;
  logic       s_out, busy, done;

  logic       enb8, dir8, s_in8, start8;
  logic [2:0] modo8;
  logic [7:0] d8;
  logic [2:0] cnt8;
  logic [7:0] q8;
  logic       s_out8, busy8, done8;

  int n_cmp = 0;
  int n_err = 0;

  registro_universal #(.WIDTH(4), .CW(3)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (enb),
    .dir   (dir),
    .s_in  (s_in),
    .modo  (modo),
    .d     (d),
    .start (start),
    .cnt   (cnt),
    .q     (q),
    .s_out (s_out),
    .busy  (busy),
    .done  (done)
  );

  registro_universal #(.WIDTH(8), .CW(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (enb8),
    .dir   (dir8),
    .s_in  (s_in8),
    .modo  (modo8),
    .d     (d8),
    .start (start8),
    .cnt   (cnt8),
    .q     (q8),
    .s_out (s_out8),
    .busy  (busy8),
    .done  (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // q, s_out, busy, done of the 4-bit instance in one go
  task automatic check4(input string tag, input logic [3:0] eq, input logic es,
                        input logic eb, input logic ed);
    check_eq({tag, ".q"},     {28'd0, q},     {28'd0, eq});
    check_eq({tag, ".s_out"}, {31'd0, s_out}, {31'd0, es});
    check_eq({tag, ".busy"},  {31'd0, busy},  {31'd0, eb});
    check_eq({tag, ".done"},  {31'd0, done},  {31'd0, ed});
  endtask

  initial begin
    rst_n = 1'b0;
    enb = 1'b0; dir = 1'b0; s_in = 1'b0; start = 1'b0; modo = 3'b011; d = '0; cnt = '0;
    enb8 = 1'b0; dir8 = 1'b0; s_in8 = 1'b0; start8 = 1'b0; modo8 = 3'b011; d8 = '0; cnt8 = '0;
    #2;
    check4("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Legacy rotate left after a parallel load
    enb = 1'b1; modo = 3'b010; d = 4'b0110;
    tick();
    check_eq("load.q", {28'd0, q}, 32'h6);
    modo = 3'b001; dir = 1'b0;
    tick(); check4("rotl1", 4'b1100, 1'b0, 1'b0, 1'b0);
    tick(); check4("rotl2", 4'b1001, 1'b1, 1'b0, 1'b0);
    tick(); check4("rotl3", 4'b0011, 1'b1, 1'b0, 1'b0);
    tick(); check4("rotl4", 4'b0110, 1'b0, 1'b0, 1'b0);

    // Burst arithmetic right, live modo changed while running
    modo = 3'b010; d = 4'b1001;
    tick();
    modo = 3'b100; dir = 1'b1; cnt = 3'd2; start = 1'b1;
    tick(); check4("asr.start", 4'b1001, 1'b0, 1'b1, 1'b0);
    start = 1'b0; modo = 3'b001; dir = 1'b0;
    tick(); check4("asr.s1", 4'b1100, 1'b1, 1'b1, 1'b0);
    tick(); check4("asr.s2", 4'b1110, 1'b0, 1'b0, 1'b1);
    tick(); check4("asr.idle", 4'b1110, 1'b0, 1'b0, 1'b0);
    modo = 3'b011;

    // Burst rotate right with a two-cycle stall
    modo = 3'b010; d = 4'b0001;
    tick();
    modo = 3'b001; dir = 1'b1; cnt = 3'd3; start = 1'b1;
    tick(); check4("stall.start", 4'b0001, 1'b0, 1'b1, 1'b0);
    start = 1'b0; modo = 3'b011;
    tick(); check4("stall.s1", 4'b1000, 1'b1, 1'b1, 1'b0);
    enb = 1'b0;
    tick(); check4("stall.h1", 4'b1000, 1'b1, 1'b1, 1'b0);
    tick(); check4("stall.h2", 4'b1000, 1'b1, 1'b1, 1'b0);
    enb = 1'b1;
    tick(); check4("stall.s2", 4'b0100, 1'b0, 1'b1, 1'b0);
    tick(); check4("stall.s3", 4'b0010, 1'b0, 1'b0, 1'b1);
    tick(); check4("stall.idle", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Degenerate starts: cnt=0, then a non-shift mode
    modo = 3'b001; dir = 1'b0; cnt = 3'd0; start = 1'b1;
    tick(); check4("cnt0.fin", 4'b0010, 1'b0, 1'b0, 1'b1);
    start = 1'b0; modo = 3'b011;
    tick(); check4("cnt0.idle", 4'b0010, 1'b0, 1'b0, 1'b0);
    modo = 3'b010; d = 4'b1111; cnt = 3'd3; start = 1'b1;
    tick(); check4("load.fin", 4'b0010, 1'b0, 1'b0, 1'b1);
    start = 1'b0; modo = 3'b011;
    tick(); check4("load.idle", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst
    modo = 3'b001; dir = 1'b0; cnt = 3'd5; start = 1'b1;
    tick();
    start = 1'b0; modo = 3'b011;
    tick(); check4("mid.s1", 4'b0100, 1'b0, 1'b1, 1'b0);
    tick(); check4("mid.s2", 4'b1000, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check4("mid.rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check4("mid.after", 4'b0000, 1'b0, 1'b0, 1'b0);

    // 8-bit instance: logical right shift filling ones, maximum burst length
    enb8 = 1'b1; modo8 = 3'b000; dir8 = 1'b1; s_in8 = 1'b1; cnt8 = 3'd7; start8 = 1'b1;
    tick();
    check_eq("w8.start.q", {24'd0, q8}, 32'h00);
    check_eq("w8.start.busy", {31'd0, busy8}, 32'd1);
    start8 = 1'b0; modo8 = 3'b010; d8 = 8'hA5;
    for (int i = 0; i < 6; i++) tick();
    check_eq("w8.s6.q", {24'd0, q8}, 32'hFC);
    check_eq("w8.s6.busy", {31'd0, busy8}, 32'd1);
    tick();
    check_eq("w8.s7.q", {24'd0, q8}, 32'hFE);
    check_eq("w8.s7.s_out", {31'd0, s_out8}, 32'd0);
    check_eq("w8.s7.busy", {31'd0, busy8}, 32'd0);
    check_eq("w8.s7.done", {31'd0, done8}, 32'd1);
    modo8 = 3'b011;
    tick();
    check_eq("w8.idle.done", {31'd0, done8}, 32'd0);
    check_eq("w8.idle.q", {24'd0, q8}, 32'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
